// File: rtl/nth_root_pkg.sv
// Shared types, width helpers and exponent check for the Nth-root engine.
package nth_root_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_t;

    // Result width: integer part plus fractional bits.
    function automatic int unsigned calc_out_w(input int unsigned in_w, input int unsigned frac_w);
        return in_w + frac_w;
    endfunction

    // Width of X scaled by 2^(N*FRAC_W) for the largest N.
    function automatic int unsigned calc_t_w(input int unsigned in_w, input int unsigned frac_w,
                                             input int unsigned max_exp);
        return in_w + max_exp * frac_w;
    endfunction

    // Accumulator is wide enough that acc*trial never wraps while acc <= target.
    function automatic int unsigned calc_acc_w(input int unsigned in_w, input int unsigned frac_w,
                                               input int unsigned max_exp);
        return calc_t_w(in_w, frac_w, max_exp) + calc_out_w(in_w, frac_w);
    endfunction

    // Exponent must be in 1..max_exp.
    function automatic logic exp_legal(input int unsigned n, input int unsigned max_exp);
        return (n != 0) && (n <= max_exp);
    endfunction

endpackage

// File: rtl/nth_root_iter_pow_cmp.sv
// Power-and-compare datapath: raises trial to N by repeated multiply, bails out on overflow.
module root_pow_cmp
    import nth_root_pkg::*;
#(
    parameter int unsigned IN_W    = 10,
    parameter int unsigned FRAC_W  = 10,
    parameter int unsigned MAX_EXP = 7,
    parameter int unsigned EXP_W   = 3
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           load,
    input  logic [calc_out_w(IN_W, FRAC_W)-1:0]            trial,
    input  logic [calc_t_w(IN_W, FRAC_W, MAX_EXP)-1:0]     target,
    input  logic [EXP_W-1:0]                               n,
    input  logic                                           mul_en,
    output logic                                           done_c,
    output logic                                           keep_c,
    output logic                                           hit_c
);

    localparam int unsigned OUT_W = calc_out_w(IN_W, FRAC_W);
    localparam int unsigned ACC_W = calc_acc_w(IN_W, FRAC_W, MAX_EXP);

    logic [ACC_W-1:0] acc_q;
    logic [OUT_W-1:0] trial_q;
    logic [EXP_W-1:0] cnt_q;
    logic             over_c;
    logic             last_c;

    // One decision per cycle: overflow, or N-th power reached.
    always_comb begin
        over_c = acc_q > ACC_W'(target);
        last_c = cnt_q == n;
        done_c = mul_en & (over_c | last_c);
        keep_c = mul_en & ~over_c & last_c;
        hit_c  = keep_c & (acc_q == ACC_W'(target));
    end

    // Accumulator and power counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            trial_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            acc_q   <= ACC_W'(trial);
            trial_q <= trial;
            cnt_q   <= EXP_W'(1);
        end else if (mul_en && !over_c && !last_c) begin
            acc_q   <= acc_q * ACC_W'(trial_q);
            cnt_q   <= cnt_q + EXP_W'(1);
        end
    end

endmodule

// File: rtl/nth_root_iter.sv
// Bit-serial Nth-root engine: Q = floor(X^(1/N) * 2^FRAC_W) with valid/ready on both sides.
module nth_root_iter
    import nth_root_pkg::*;
#(
    parameter int unsigned IN_W    = 10,
    parameter int unsigned FRAC_W  = 10,
    parameter int unsigned MAX_EXP = 7,
    parameter int unsigned EXP_W   = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [IN_W-1:0]                     in_data_1,
    input  logic [EXP_W-1:0]                    in_data_2,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [calc_out_w(IN_W, FRAC_W)-1:0] out_data,
    output logic                                out_exact,
    output logic                                out_err
);

    localparam int unsigned OUT_W = calc_out_w(IN_W, FRAC_W);
    localparam int unsigned T_W   = calc_t_w(IN_W, FRAC_W, MAX_EXP);
    localparam logic [OUT_W-1:0] MSB_BIT = OUT_W'(1) << (OUT_W - 1);

    state_t           state_q, state_d;
    logic [EXP_W-1:0] n_q, n_d;
    logic [T_W-1:0]   target_q, target_d;
    logic [OUT_W-1:0] res_q, res_d, bit_q, bit_d, res_new_c, trial_c;
    logic             keep_q, keep_d, hit_q, hit_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_exact_q, out_exact_d, out_err_q, out_err_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic             load_c, mul_en_c;
    logic             pow_done_c, pow_keep_c, pow_hit_c;

    root_pow_cmp #(
        .IN_W    (IN_W),
        .FRAC_W  (FRAC_W),
        .MAX_EXP (MAX_EXP),
        .EXP_W   (EXP_W)
    ) u_pow (
        .clk    (clk),
        .rst    (rst),
        .load   (load_c),
        .trial  (trial_c),
        .target (target_q),
        .n      (n_q),
        .mul_en (mul_en_c),
        .done_c (pow_done_c),
        .keep_c (pow_keep_c),
        .hit_c  (pow_hit_c)
    );

    // Next-state, datapath updates and registered-output next values.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        target_d    = target_q;
        res_d       = res_q;
        bit_d       = bit_q;
        keep_d      = keep_q;
        hit_d       = hit_q;
        out_data_d  = out_data_q;
        out_exact_d = out_exact_q;
        out_err_d   = out_err_q;
        load_c      = 1'b0;
        trial_c     = '0;
        mul_en_c    = state_q == MUL;
        res_new_c   = keep_q ? (res_q | bit_q) : res_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    n_d      = in_data_2;
                    target_d = T_W'(in_data_1) << (32'(in_data_2) * FRAC_W);
                    if (!exp_legal(32'(in_data_2), MAX_EXP)) begin
                        state_d   = DONE;
                        out_err_d = 1'b1;
                    end else if (in_data_1 == '0) begin
                        state_d     = DONE;
                        out_exact_d = 1'b1;
                    end else if (in_data_2 == EXP_W'(1)) begin
                        state_d     = DONE;
                        out_data_d  = OUT_W'(in_data_1) << FRAC_W;
                        out_exact_d = 1'b1;
                    end else begin
                        state_d = MUL;
                        bit_d   = MSB_BIT;
                        res_d   = '0;
                        load_c  = 1'b1;
                        trial_c = MSB_BIT;
                    end
                end
            end
            MUL: begin
                if (pow_done_c) begin
                    state_d = STEP;
                    keep_d  = pow_keep_c;
                    hit_d   = pow_hit_c;
                end
            end
            STEP: begin
                res_d = res_new_c;
                if ((keep_q && hit_q) || bit_q[0]) begin
                    state_d     = DONE;
                    out_data_d  = res_new_c;
                    out_exact_d = keep_q & hit_q;
                end else begin
                    state_d = MUL;
                    bit_d   = bit_q >> 1;
                    load_c  = 1'b1;
                    trial_c = res_new_c | (bit_q >> 1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_data_d  = '0;
                    out_exact_d = 1'b0;
                    out_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = state_d == IDLE;
        out_valid_d = state_d == DONE;
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            target_q    <= '0;
            res_q       <= '0;
            bit_q       <= '0;
            keep_q      <= 1'b0;
            hit_q       <= 1'b0;
            out_data_q  <= '0;
            out_exact_q <= 1'b0;
            out_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            target_q    <= target_d;
            res_q       <= res_d;
            bit_q       <= bit_d;
            keep_q      <= keep_d;
            hit_q       <= hit_d;
            out_data_q  <= out_data_d;
            out_exact_q <= out_exact_d;
            out_err_q   <= out_err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_exact = out_exact_q;
    assign out_err   = out_err_q;

endmodule
